bsg_cache_tb_tracker: RTL and testbench
=======================================

BSG_CACHE_TB_TRACKER -- requirements
Module: bsg_cache_tb_tracker

Interface
REQ-001 SHALL have parameter channels_p, default 4, number of independent request/response channels (>=1).
REQ-002 SHALL have parameter count_width_p, default 16, width of the sent and received total counters.
REQ-003 SHALL have parameter max_outstanding_p, default 8, maximum outstanding requests per channel (>=1).
REQ-004 SHALL have parameter timeout_p, default 1000, watchdog limit in cycles without forward progress (>=1).
REQ-005 SHALL have port clk, input, 1, clock.
REQ-006 SHALL have port reset, input, 1, reset, synchronous, active-high.
REQ-007 SHALL have port send_v_i, input, channels_p, request accepted by the DUT on channel i.
REQ-008 SHALL have port recv_v_i, input, channels_p, response consumed on channel i (valid and yumi both high).
REQ-009 SHALL have port trace_done_i, input, 1, stimulus source has issued its final request.
REQ-010 SHALL have port credit_o, output, channels_p, channel i may issue a request this cycle.
REQ-011 SHALL have port outstanding_o, output, channels_p*$clog2(max_outstanding_p+1), per-channel outstanding count, channel 0 in the LSBs.
REQ-012 SHALL have ports sent_total_o and recv_total_o, output, count_width_p each, totals summed across all channels.
REQ-013 SHALL have ports done_o (1), error_o (1), error_code_o (3) and error_chan_o ($clog2(channels_p), min 1), all outputs.

Function
REQ-014 SHALL keep one outstanding counter per channel: +1 on send only, -1 on recv only, unchanged when both occur, visible on outputs the cycle after the event.
REQ-015 SHALL increment sent_total_o by popcount(send_v_i) and recv_total_o by popcount(recv_v_i) each cycle, saturating at all-ones.
REQ-016 SHALL drive credit_o[i] = (outstanding[i] < max_outstanding_p) and state in {RUN, DRAIN}; the path is combinational from registers only.
REQ-017 SHALL implement the FSM RUN -> DRAIN on trace_done_i; DRAIN -> DONE when all outstanding counters are zero (registered values); any state except ERROR -> ERROR on an error event.
REQ-018 SHALL flag underflow (code 1) on recv_v_i[i] while outstanding[i]==0, including when send_v_i[i] is high in the same cycle.
REQ-019 SHALL flag overflow (code 2) on send_v_i[i] while outstanding[i]==max_outstanding_p and recv_v_i[i] is low.
REQ-020 SHALL flag timeout (code 3) when any counter is nonzero and no recv occurs on any channel for timeout_p consecutive cycles; the watchdog clears on any recv and while all counters are zero.
REQ-021 SHALL flag late send (code 4) on any send_v_i while in DONE.
REQ-022 SHALL, on simultaneous errors, report the lowest code, and within that code the lowest channel index; timeout reports channel 0.
REQ-023 SHALL hold ERROR, error_code_o and error_chan_o sticky until reset; counters freeze in ERROR.
REQ-024 SHALL assert done_o only in DONE and error_o only in ERROR; error_code_o is 0 otherwise.

Reset
REQ-025 SHALL, on reset, enter RUN and clear all counters, the watchdog, done_o, error_o, error_code_o and error_chan_o; credit_o is all-ones the following cycle.
REQ-026 SHALL let reset asserted mid-operation override all events in that cycle, including trace_done_i.

Structure
REQ-027 SHALL place the state enum (RUN, DRAIN, DONE, ERROR) and the error-code enum (NONE=0, UNDERFLOW=1, OVERFLOW=2, TIMEOUT=3, LATE_SEND=4) in the shared package bsg_cache_tb_tracker_pkg.
REQ-028 SHALL instantiate the sub-module bsg_cache_tb_tracker_chan once per channel; it holds one counter and produces that channel's underflow and overflow flags.

Verification
REQ-029 Test: channels_p=2, 3 sends on ch0 then 3 recvs, then trace_done_i -> DRAIN, then done_o=1 two cycles later; sent_total=recv_total=3.
REQ-030 Test: max_outstanding_p=8, 8 sends on ch1 -> credit_o[1]=0; 9th send -> error_code=2, error_chan=1.
REQ-031 Test: recv on ch3 with outstanding=0 and simultaneous send on ch3 -> error_code=1, error_chan=3.
REQ-032 Test: timeout_p=10, 1 outstanding on ch0, no recv -> error_o rises on the 10th idle cycle, code 3.
REQ-033 Test: in DONE, a send on ch0 -> code 4; reset asserted in the same cycle as trace_done_i -> state RUN, all outputs zero.

Source files
------------

// File: rtl/bsg_cache_tb_tracker_pkg.sv
// Shared types for the testbench request/response tracker: FSM states and
// error codes reported on error_code_o.
package bsg_cache_tb_tracker_pkg;

    typedef enum logic [1:0] {
        e_run   = 2'd0,
        e_drain = 2'd1,
        e_done  = 2'd2,
        e_error = 2'd3
    } tracker_state_e;

    typedef enum logic [2:0] {
        e_err_none      = 3'd0,
        e_err_underflow = 3'd1,
        e_err_overflow  = 3'd2,
        e_err_timeout   = 3'd3,
        e_err_late_send = 3'd4
    } tracker_err_e;

endpackage

// File: rtl/bsg_cache_tb_tracker_chan.sv
// One channel of the tracker: outstanding-request counter plus that channel's
// underflow/overflow detection against the registered count.
module bsg_cache_tb_tracker_chan #(
    parameter int max_outstanding_p = 8,
    parameter int cnt_width_lp      = $clog2(max_outstanding_p + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en_i,
    input  logic                    send_v_i,
    input  logic                    recv_v_i,
    output logic [cnt_width_lp-1:0] count_o,
    output logic                    below_max_o,
    output logic                    underflow_o,
    output logic                    overflow_o
);

    localparam logic [cnt_width_lp-1:0] max_lp = cnt_width_lp'(max_outstanding_p);

    logic [cnt_width_lp-1:0] count_r;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
        end else if (en_i) begin
            if (send_v_i && !recv_v_i) begin
                count_r <= count_r + cnt_width_lp'(1);
            end else if (recv_v_i && !send_v_i) begin
                count_r <= count_r - cnt_width_lp'(1);
            end
        end
    end

    assign count_o     = count_r;
    assign below_max_o = (count_r < max_lp);
    assign underflow_o = recv_v_i && (count_r == '0);
    assign overflow_o  = send_v_i && !recv_v_i && (count_r == max_lp);

endmodule

// File: rtl/bsg_cache_tb_tracker.sv
// Tracks outstanding requests per channel for a cache testbench, detects
// protocol errors and a stalled DUT, and signals when the trace has drained.
module bsg_cache_tb_tracker
    import bsg_cache_tb_tracker_pkg::*;
#(
    parameter int channels_p        = 4,
    parameter int count_width_p     = 16,
    parameter int max_outstanding_p = 8,
    parameter int timeout_p         = 1000
) (
    input  logic                                                  clk,
    input  logic                                                  reset,
    input  logic [channels_p-1:0]                                 send_v_i,
    input  logic [channels_p-1:0]                                 recv_v_i,
    input  logic                                                  trace_done_i,
    output logic [channels_p-1:0]                                 credit_o,
    output logic [channels_p*$clog2(max_outstanding_p+1)-1:0]     outstanding_o,
    output logic [count_width_p-1:0]                              sent_total_o,
    output logic [count_width_p-1:0]                              recv_total_o,
    output logic                                                  done_o,
    output logic                                                  error_o,
    output logic [2:0]                                            error_code_o,
    output logic [((channels_p > 1) ? $clog2(channels_p) : 1)-1:0] error_chan_o
);

    localparam int cnt_width_lp   = $clog2(max_outstanding_p + 1);
    localparam int chan_width_lp  = (channels_p > 1) ? $clog2(channels_p) : 1;
    localparam int timer_width_lp = (timeout_p > 1) ? $clog2(timeout_p) : 1;
    localparam logic [timer_width_lp-1:0] timer_last_lp = timer_width_lp'(timeout_p - 1);

    tracker_state_e             state_r, state_n;
    tracker_err_e               err_code_r, err_code_n;
    logic [chan_width_lp-1:0]   err_chan_r, err_chan_n;
    logic [timer_width_lp-1:0]  wd_r;
    logic [count_width_p-1:0]   sent_r, recv_r, sent_n, recv_n;

    logic [cnt_width_lp-1:0]    count   [channels_p];
    logic [channels_p-1:0]      below_max, underflow, overflow, nonzero;
    logic                       any_nonzero, any_recv, timeout_hit, err_event, freeze;

    function automatic logic [chan_width_lp-1:0] lowest_idx(input logic [channels_p-1:0] v);
        logic [chan_width_lp-1:0] idx;
        idx = '0;
        for (int i = channels_p - 1; i >= 0; i--) begin
            if (v[i]) idx = chan_width_lp'(i);
        end
        return idx;
    endfunction

    for (genvar i = 0; i < channels_p; i++) begin : g_chan
        bsg_cache_tb_tracker_chan #(
            .max_outstanding_p(max_outstanding_p)
        ) chan (
            .clk        (clk),
            .reset      (reset),
            .en_i       (~freeze),
            .send_v_i   (send_v_i[i]),
            .recv_v_i   (recv_v_i[i]),
            .count_o    (count[i]),
            .below_max_o(below_max[i]),
            .underflow_o(underflow[i]),
            .overflow_o (overflow[i])
        );
        assign nonzero[i] = (count[i] != '0);
        assign outstanding_o[i*cnt_width_lp +: cnt_width_lp] = count[i];
    end

    assign any_nonzero = |nonzero;
    assign any_recv    = |recv_v_i;
    assign timeout_hit = any_nonzero && !any_recv && (wd_r == timer_last_lp);

    // Lowest code wins; within a code the lowest channel index wins.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        err_code_n = e_err_none;
        err_chan_n = '0;
        if (state_r != e_error) begin
            if (|underflow) begin
                err_code_n = e_err_underflow;
                err_chan_n = lowest_idx(underflow);
            end else if (|overflow) begin
                err_code_n = e_err_overflow;
                err_chan_n = lowest_idx(overflow);
            end else if (timeout_hit) begin
                err_code_n = e_err_timeout;
            end else if (state_r == e_done && |send_v_i) begin
                err_code_n = e_err_late_send;
                err_chan_n = lowest_idx(send_v_i);
            end
        end
    end

    assign err_event = (err_code_n != e_err_none);
    assign freeze    = (state_r == e_error) || err_event;

    always_comb begin
        state_n = state_r;
        case (state_r)
            e_run:   if (trace_done_i) state_n = e_drain;
            e_drain: if (!any_nonzero) state_n = e_done;
            default: state_n = state_r;
        endcase
        if (err_event) state_n = e_error;
    end

    // Saturating totals: add in one extra bit and clamp on carry-out.
    always_comb begin
        logic [count_width_p:0] sent_sum, recv_sum;
        sent_sum = {1'b0, sent_r};
        recv_sum = {1'b0, recv_r};
        for (int i = 0; i < channels_p; i++) begin
            sent_sum = sent_sum + (count_width_p + 1)'(send_v_i[i]);
            recv_sum = recv_sum + (count_width_p + 1)'(recv_v_i[i]);
        end
        sent_n = sent_sum[count_width_p] ? '1 : sent_sum[count_width_p-1:0];
        recv_n = recv_sum[count_width_p] ? '1 : recv_sum[count_width_p-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= e_run;
            err_code_r <= e_err_none;
            err_chan_r <= '0;
            wd_r       <= '0;
            sent_r     <= '0;
            recv_r     <= '0;
        end else begin
            state_r <= state_n;
            if (err_event) begin
                err_code_r <= err_code_n;
                err_chan_r <= err_chan_n;
            end
            if (!any_nonzero || any_recv) begin
                wd_r <= '0;
            end else if (!freeze) begin
                wd_r <= wd_r + timer_width_lp'(1);
            end
            if (!freeze) begin
                sent_r <= sent_n;
                recv_r <= recv_n;
            end
        end
    end

    assign credit_o     = below_max & {channels_p{(state_r == e_run) || (state_r == e_drain)}};
    assign sent_total_o = sent_r;
    assign recv_total_o = recv_r;
    assign done_o       = (state_r == e_done);
    assign error_o      = (state_r == e_error);
    assign error_code_o = err_code_r;
    assign error_chan_o = err_chan_r;

endmodule

// File: tb/tb_bsg_cache_tb_tracker.sv
// Directed bench for bsg_cache_tb_tracker: expectations are queued as stimulus
// is driven and drained against the outputs after the clock edge.
module tb_bsg_cache_tb_tracker;

    localparam int CH = 4;

    localparam int SEL_CREDIT = 0;
    localparam int SEL_OUTST  = 1;
    localparam int SEL_SENT   = 2;
    localparam int SEL_RECV   = 3;
    localparam int SEL_DONE   = 4;
    localparam int SEL_ERROR  = 5;
    localparam int SEL_CODE   = 6;
    localparam int SEL_CHAN   = 7;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] send_v_i, recv_v_i;
    logic          trace_done_i;
    logic [CH-1:0] credit_o;
    logic [15:0]   outstanding_o;
    logic [15:0]   sent_total_o, recv_total_o;
    logic          done_o, error_o;
    logic [2:0]    error_code_o;
    logic [1:0]    error_chan_o;

    exp_t exp_q[$];
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    bsg_cache_tb_tracker #(
        .channels_p       (CH),
        .count_width_p    (16),
        .max_outstanding_p(8),
        .timeout_p        (10)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .send_v_i     (send_v_i),
        .recv_v_i     (recv_v_i),
        .trace_done_i (trace_done_i),
        .credit_o     (credit_o),
        .outstanding_o(outstanding_o),
        .sent_total_o (sent_total_o),
        .recv_total_o (recv_total_o),
        .done_o       (done_o),
        .error_o      (error_o),
        .error_code_o (error_code_o),
        .error_chan_o (error_chan_o)
    );

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_CREDIT: return 32'(credit_o);
            SEL_OUTST:  return 32'(outstanding_o);
            SEL_SENT:   return 32'(sent_total_o);
            SEL_RECV:   return 32'(recv_total_o);
            SEL_DONE:   return 32'(done_o);
            SEL_ERROR:  return 32'(error_o);
            SEL_CODE:   return 32'(error_code_o);
            default:    return 32'(error_chan_o);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    task automatic expect_val(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic expect_idle_reset(input string tag);
        expect_val({tag, "_credit"}, SEL_CREDIT, 32'hF);
        expect_val({tag, "_outst"},  SEL_OUTST,  32'h0);
        expect_val({tag, "_sent"},   SEL_SENT,   32'h0);
        expect_val({tag, "_recv"},   SEL_RECV,   32'h0);
        expect_val({tag, "_done"},   SEL_DONE,   32'h0);
        expect_val({tag, "_error"},  SEL_ERROR,  32'h0);
        expect_val({tag, "_code"},   SEL_CODE,   32'h0);
        expect_val({tag, "_chan"},   SEL_CHAN,   32'h0);
    endtask

    // Drive one cycle of stimulus at the falling edge, then score after the
    // following falling edge.
    task automatic step(input logic [CH-1:0] send, input logic [CH-1:0] recv,
                        input logic td, input logic rst);
        exp_t e;
        send_v_i     = send;
        recv_v_i     = recv;
        trace_done_i = td;
        reset        = rst;
        @(posedge clk);
        @(negedge clk);
        send_v_i     = '0;
        recv_v_i     = '0;
        trace_done_i = 1'b0;
        reset        = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.tag, observe(e.sel), e.val);
        end
    endtask

    initial begin
        reset        = 1'b1;
        send_v_i     = '0;
        recv_v_i     = '0;
        trace_done_i = 1'b0;
        @(negedge clk);

        expect_idle_reset("reset");
        step('0, '0, 1'b0, 1'b1);

        // Three requests on channel 0, then three responses, then drain.
        step(4'b0001, '0, 1'b0, 1'b0);
        step(4'b0001, '0, 1'b0, 1'b0);
        expect_val("fill_outst", SEL_OUTST, 32'h3);
        step(4'b0001, '0, 1'b0, 1'b0);
        step('0, 4'b0001, 1'b0, 1'b0);
        step('0, 4'b0001, 1'b0, 1'b0);
        expect_val("empty_outst", SEL_OUTST, 32'h0);
        expect_val("empty_sent",  SEL_SENT,  32'd3);
        expect_val("empty_recv",  SEL_RECV,  32'd3);
        step('0, 4'b0001, 1'b0, 1'b0);
        expect_val("drain_done",   SEL_DONE,   32'h0);
        expect_val("drain_credit", SEL_CREDIT, 32'hF);
        step('0, '0, 1'b1, 1'b0);
        expect_val("done_done",   SEL_DONE,   32'h1);
        expect_val("done_credit", SEL_CREDIT, 32'h0);
        step('0, '0, 1'b0, 1'b0);

        // A send after completion is a late send; error state is sticky.
        expect_val("late_error", SEL_ERROR, 32'h1);
        expect_val("late_done",  SEL_DONE,  32'h0);
        expect_val("late_code",  SEL_CODE,  32'h4);
        expect_val("late_chan",  SEL_CHAN,  32'h0);
        expect_val("late_sent",  SEL_SENT,  32'd3);
        step(4'b0001, '0, 1'b0, 1'b0);
        expect_val("sticky_code",  SEL_CODE,  32'h4);
        expect_val("sticky_error", SEL_ERROR, 32'h1);
        step(4'b0010, '0, 1'b0, 1'b0);

        // Reset wins over trace_done in the same cycle.
        expect_idle_reset("rst_td");
        step('0, '0, 1'b1, 1'b1);
        expect_val("rst_td_run_done",   SEL_DONE,   32'h0);
        expect_val("rst_td_run_credit", SEL_CREDIT, 32'hF);
        step('0, '0, 1'b0, 1'b0);

        // Fill channel 1 to the limit, then overflow it.
        for (int i = 0; i < 7; i++) step(4'b0010, '0, 1'b0, 1'b0);
        expect_val("full_credit", SEL_CREDIT, 32'b1101);
        expect_val("full_outst",  SEL_OUTST,  32'h0080);
        expect_val("full_sent",   SEL_SENT,   32'd8);
        step(4'b0010, '0, 1'b0, 1'b0);
        expect_val("ovf_error",  SEL_ERROR,  32'h1);
        expect_val("ovf_code",   SEL_CODE,   32'h2);
        expect_val("ovf_chan",   SEL_CHAN,   32'h1);
        expect_val("ovf_outst",  SEL_OUTST,  32'h0080);
        expect_val("ovf_credit", SEL_CREDIT, 32'h0);
        step(4'b0010, '0, 1'b0, 1'b0);

        // Underflow on channel 3 even with a send in the same cycle.
        step('0, '0, 1'b0, 1'b1);
        expect_val("unf_code",  SEL_CODE,  32'h1);
        expect_val("unf_chan",  SEL_CHAN,  32'h3);
        expect_val("unf_outst", SEL_OUTST, 32'h0);
        step(4'b1000, 4'b1000, 1'b0, 1'b0);

        // Two simultaneous underflows: lowest channel reported.
        step('0, '0, 1'b0, 1'b1);
        expect_val("prio_code", SEL_CODE, 32'h1);
        expect_val("prio_chan", SEL_CHAN, 32'h2);
        step('0, 4'b1100, 1'b0, 1'b0);

        // Send and receive together on a channel leave its count unchanged.
        step('0, '0, 1'b0, 1'b1);
        step(4'b0100, '0, 1'b0, 1'b0);
        expect_val("both_outst", SEL_OUTST, 32'h0100);
        expect_val("both_sent",  SEL_SENT,  32'd2);
        expect_val("both_recv",  SEL_RECV,  32'd1);
        expect_val("both_error", SEL_ERROR, 32'h0);
        step(4'b0100, 4'b0100, 1'b0, 1'b0);
        expect_val("both_final_outst", SEL_OUTST, 32'h0);
        step('0, 4'b0100, 1'b0, 1'b0);

        // Watchdog: one request with no response trips on the tenth idle cycle.
        step('0, '0, 1'b0, 1'b1);
        step(4'b0001, '0, 1'b0, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            expect_val($sformatf("wd_idle%0d", i), SEL_ERROR, 32'h0);
            step('0, '0, 1'b0, 1'b0);
        end
        expect_val("wd_error", SEL_ERROR, 32'h1);
        expect_val("wd_code",  SEL_CODE,  32'h3);
        expect_val("wd_chan",  SEL_CHAN,  32'h0);
        step('0, '0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
